program_loader: RTL and testbench

Boot-time UART program loader that sits directly upstream of the multicycle control unit. Receives a length-prefixed instruction image over the Basys3 USB-UART and writes it word by word into the 1024-word instruction memory. When loading completes, it raises `top_en` to release the control unit into IF. Holds the processor idle for the whole load, and permanently if the image is malformed.

---
 rtl/program_loader.sv | 204 ++++++++++++++++++++
 tb/tb_program_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time UART loader: receives a length-prefixed 32-bit instruction image (8N1, LSB first)
// and writes it word by word into instruction memory, then releases the control unit via top_en.
module program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10
) (
    input  logic              fast_clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              top_en,
    output logic              load_busy,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [32:0]      DEPTH   = 33'(1) << ADDR_W;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {HDR_HI, HDR_LO, WORD, DONE, ERR} ld_state_t;

    logic             sync1_q, sync2_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err;

    ld_state_t        state_q, state_d;
    logic [7:0]       hdr_hi_q, hdr_hi_d;
    logic [15:0]      count_q, count_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      asm_q, asm_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             top_en_q, top_en_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [ADDR_W:0]  wl_q, wl_d;
    logic [15:0]      hdr_cnt;
    logic             last_word;

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            sync1_q      <= uart_rx;
            sync2_q      <= sync1_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    // Counter starts at 1 on detection so the start check lands CLKS_PER_BIT/2 after the synced edge.
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = CNT_W'(1);
                end
            end
            RX_START: if (cnt_q == HALF_M1) begin
                cnt_d      = '0;
                bit_d      = '0;
                rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL_M1) begin
                cnt_d   = '0;
                shift_d = {sync2_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL_M1) begin
                cnt_d        = '0;
                rx_state_d   = RX_IDLE;
                byte_valid_d = sync2_q;
                frame_err    = !sync2_q;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HDR_HI;
            hdr_hi_q   <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            top_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            wl_q       <= '0;
        end else begin
            state_q    <= state_d;
            hdr_hi_q   <= hdr_hi_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            top_en_q   <= top_en_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            wl_q       <= wl_d;
        end
    end

    assign hdr_cnt   = {hdr_hi_q, shift_q};
    assign last_word = (33'(wl_q) + 33'd1) == 33'(count_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI: if (frame_err) state_d = ERR;
                    else if (byte_valid_q) state_d = HDR_LO;
            HDR_LO: if (frame_err) state_d = ERR;
                    else if (byte_valid_q) begin
                        if (hdr_cnt == 16'd0)           state_d = DONE;
                        else if (33'(hdr_cnt) > DEPTH)  state_d = ERR;
                        else                            state_d = WORD;
                    end
            WORD:   if (frame_err) state_d = ERR;
                    else if (byte_valid_q && byte_idx_q == 2'd3 && last_word) state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    // DONE and ERR are absorbing: nothing below reacts to bytes once either is reached.
    always_comb begin
        hdr_hi_d   = hdr_hi_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        mem_we_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wl_d       = wl_q;
        busy_d     = busy_q;
        top_en_d   = top_en_q | (state_q == DONE) | (state_q == HDR_LO && state_d == DONE);
        err_d      = err_q | (state_d == ERR);
        if (byte_valid_q) begin
            case (state_q)
                HDR_HI: begin
                    hdr_hi_d = shift_q;
                    busy_d   = 1'b1;
                end
                HDR_LO: begin
                    count_d    = hdr_cnt;
                    wl_d       = '0;
                    byte_idx_d = '0;
                end
                WORD: begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d = 1'b1;
                        wdata_d  = {asm_q, shift_q};
                        addr_d   = wl_q[ADDR_W-1:0];
                        wl_d     = wl_q + (ADDR_W+1)'(1);
                    end else begin
                        asm_d = {asm_q[15:0], shift_q};
                    end
                end
                default: ;
            endcase
        end
        if (state_d == DONE || state_d == ERR) busy_d = 1'b0;
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign top_en       = top_en_q;
    assign load_busy    = busy_q;
    assign load_err     = err_q;
    assign words_loaded = wl_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: UART byte driver, write scoreboard and edge-timing monitor.
module tb_program_loader;
    logic        fast_clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        top_en, load_busy, load_err;
    logic [10:0] words_loaded;

    program_loader #(.CLKS_PER_BIT(16), .ADDR_W(10)) dut (
        .fast_clk(fast_clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .top_en(top_en), .load_busy(load_busy), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 fast_clk = ~fast_clk;

    int cyc = 0;
    always @(posedge fast_clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    logic [41:0] exp_q[$];
    int start_cyc, we_cyc, top_rise, busy_rise, busy_fall, err_rise;
    int s1, s2;
    logic top_p = 1'b0, busy_p = 1'b0, err_p = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge fast_clk);
        #1;
    endtask

    // Start bit goes low 1 time unit after an edge; start_cyc is that edge's count.
    task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
        @(posedge fast_clk); #1;
        start_cyc = cyc;
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(b[i], 16);
        if (bad_stop) begin
            hold(1'b0, 12);
            hold(1'b1, 44);
        end else begin
            hold(1'b1, 36);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic expect_write(input logic [9:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},    64'(mem_we), 64'd0);
        check({tag, "_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_top"},   64'(top_en), 64'd0);
        check({tag, "_busy"},  64'(load_busy), 64'd0);
        check({tag, "_err"},   64'(load_err), 64'd0);
        check({tag, "_wl"},    64'(words_loaded), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge fast_clk); #1;
        rst_n = 1'b0;
        #1;
        we_cyc = -1; top_rise = -1; busy_rise = -1; busy_fall = -1; err_rise = -1;
        check_reset_values("rst");
        check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge fast_clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge fast_clk);
        #1;
    endtask

    initial begin
        logic [41:0] e;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        we_cyc = -1; top_rise = -1; busy_rise = -1; busy_fall = -1; err_rise = -1;
        fork
            forever begin
                @(negedge fast_clk);
                if (rst_n && mem_we) begin
                    we_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("we_unexpected", 64'(mem_we), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("we_addr",  64'(mem_addr), 64'(e[41:32]));
                        check("we_wdata", 64'(mem_wdata), 64'(e[31:0]));
                    end
                end
                if (top_en && !top_p) top_rise = cyc;
                if (load_busy && !busy_p) busy_rise = cyc;
                if (!load_busy && busy_p) busy_fall = cyc;
                if (load_err && !err_p) err_rise = cyc;
                top_p = top_en; busy_p = load_busy; err_p = load_err;
            end
        join_none

        #12;
        check_reset_values("por");
        repeat (2) @(posedge fast_clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge fast_clk);
        #1;

        // Two-word image, then a stray byte after DONE
        expect_write(10'd0, 32'h2008_0005);
        expect_write(10'd1, 32'hAC08_0004);
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h2008_0005); send_word(32'hAC08_0004);
        check("n2_we_timing", 64'(we_cyc), 64'(start_cyc + 155));
        check("n2_top_timing", 64'(top_rise), 64'(we_cyc + 1));
        send_byte(8'h55);
        check("n2_all_written", 64'(exp_q.size()), 64'd0);
        check("n2_wl", 64'(words_loaded), 64'd2);
        check("n2_top", 64'(top_en), 64'd1);
        check("n2_err", 64'(load_err), 64'd0);
        check("n2_busy", 64'(load_busy), 64'd0);
        check("n2_addr_hold", 64'(mem_addr), 64'd1);
        check("n2_wdata_hold", 64'(mem_wdata), 64'hAC08_0004);

        // Empty image
        do_reset();
        send_byte(8'h00); s1 = start_cyc;
        send_byte(8'h00); s2 = start_cyc;
        check("n0_busy_rise", 64'(busy_rise), 64'(s1 + 155));
        check("n0_busy_fall", 64'(busy_fall), 64'(s2 + 155));
        check("n0_top_timing", 64'(top_rise), 64'(s2 + 155));
        check("n0_top", 64'(top_en), 64'd1);
        check("n0_wl", 64'(words_loaded), 64'd0);
        check("n0_we_none", 64'(we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Framing error on the second byte of the first word
        do_reset();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22, 1'b1);
        check("ferr_timing", 64'(err_rise), 64'(start_cyc + 154));
        check("ferr_err", 64'(load_err), 64'd1);
        check("ferr_busy", 64'(load_busy), 64'd0);
        send_word(32'h3344_5566);
        send_word(32'h7788_99AA);
        check("ferr_err_sticky", 64'(load_err), 64'd1);
        check("ferr_top", 64'(top_en), 64'd0);
        check("ferr_wl", 64'(words_loaded), 64'd0);
        check("ferr_we_none", 64'(we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Short low glitch, then a valid one-word image
        do_reset();
        hold(1'b0, 4);
        hold(1'b1, 200);
        check("glitch_busy", 64'(load_busy), 64'd0);
        check("glitch_err", 64'(load_err), 64'd0);
        expect_write(10'd0, 32'h1234_5678);
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h1234_5678);
        check("glitch_all_written", 64'(exp_q.size()), 64'd0);
        check("glitch_top", 64'(top_en), 64'd1);
        check("glitch_wl", 64'(words_loaded), 64'd1);
        check("glitch_err_after", 64'(load_err), 64'd0);

        // Oversized header: 1025 words
        do_reset();
        send_byte(8'h04); send_byte(8'h01);
        check("big_err_timing", 64'(err_rise), 64'(start_cyc + 155));
        check("big_err", 64'(load_err), 64'd1);
        check("big_busy", 64'(load_busy), 64'd0);
        check("big_top", 64'(top_en), 64'd0);
        send_word(32'hFFFF_FFFF);
        check("big_we_none", 64'(we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset after 5 bytes of an image, then resend a full image
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
        check("abort_busy_before", 64'(load_busy), 64'd1);
        do_reset();
        expect_write(10'd0, 32'h0123_4567);
        expect_write(10'd1, 32'h89AB_CDEF);
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h0123_4567); send_word(32'h89AB_CDEF);
        check("reload_all_written", 64'(exp_q.size()), 64'd0);
        check("reload_wl", 64'(words_loaded), 64'd2);
        check("reload_top", 64'(top_en), 64'd1);
        check("reload_err", 64'(load_err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
